// File: rtl/scaler_interp_core.sv
// scaler_interp_core: three-stage bilinear / nearest-neighbour interpolator.
// Four neighbouring source pixels plus u/v fractions in, one pixel out per
// accepted beat. A single global stall (adv) freezes every stage at once.
module scaler_interp_core #(
  parameter int CH_NUM     = 3,
  parameter int CH_WIDTH   = 8,
  parameter int FRAC_WIDTH = 6
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         mode,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CH_NUM*CH_WIDTH-1:0]   p00,
  input  logic [CH_NUM*CH_WIDTH-1:0]   p01,
  input  logic [CH_NUM*CH_WIDTH-1:0]   p10,
  input  logic [CH_NUM*CH_WIDTH-1:0]   p11,
  input  logic [FRAC_WIDTH-1:0]        u_frac,
  input  logic [FRAC_WIDTH-1:0]        v_frac,
  input  logic                         x_edge,
  input  logic                         y_edge,
  input  logic                         in_sol,
  input  logic                         in_eol,
  input  logic                         in_sof,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CH_NUM*CH_WIDTH-1:0]   dout,
  output logic                         out_sol,
  output logic                         out_eol,
  output logic                         out_sof,
  output logic [15:0]                  pix_cnt
);

  localparam int PIX_W = CH_NUM * CH_WIDTH;
  localparam int W_W   = 2 * FRAC_WIDTH + 2;  // weight width
  localparam int M_W   = W_W + CH_WIDTH;      // product width
  localparam int S_W   = M_W + 2;             // sum of four products

  localparam logic [FRAC_WIDTH:0] ONE   = {1'b1, {FRAC_WIDTH{1'b0}}};
  localparam logic [W_W-1:0]      W_ONE = W_W'(1) << (2 * FRAC_WIDTH);
  localparam logic [S_W-1:0]      HALF  = S_W'(1) << (2 * FRAC_WIDTH - 1);
  // r > 2^CH_WIDTH-1 is the same as s >= 2^(CH_WIDTH+2F)
  localparam logic [S_W-1:0]      SAT   = S_W'(1) << (2 * FRAC_WIDTH + CH_WIDTH);

  // Index order for the four neighbours: {v, u} -> 0:p00 1:p01 2:p10 3:p11
  logic                          adv;
  logic [3:0][PIX_W-1:0]         ePix;
  logic [FRAC_WIDTH:0]           aW, bW;
  logic [3:0][W_W-1:0]           wNext;

  logic                          s1Valid;
  logic [3:0][W_W-1:0]           s1W;
  logic [3:0][PIX_W-1:0]         s1Pix;
  logic [2:0]                    s1Sb;

  logic [3:0][CH_NUM-1:0][M_W-1:0] mNext;
  logic                          s2Valid;
  logic [3:0][CH_NUM-1:0][M_W-1:0] s2M;
  logic [2:0]                    s2Sb;

  logic [S_W-1:0]                sAcc;
  logic [PIX_W-1:0]              rNext;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Edge replication of missing right column / bottom row
  always_comb begin
    ePix[0] = p00;
    ePix[1] = p01;
    ePix[2] = p10;
    ePix[3] = p11;
    if (x_edge) begin
      ePix[1] = p00;
      ePix[3] = p10;
    end
    if (y_edge) begin
      ePix[2] = p00;
      ePix[3] = x_edge ? p00 : p01;
    end
  end

  // Exact weights (sum = 2^2F), or one-hot for nearest mode
  always_comb begin
    aW    = ONE - {1'b0, u_frac};
    bW    = ONE - {1'b0, v_frac};
    wNext = '0;
    if (mode) begin
      wNext[{v_frac[FRAC_WIDTH-1], u_frac[FRAC_WIDTH-1]}] = W_ONE;
    end else begin
      wNext[0] = W_W'(aW)     * W_W'(bW);
      wNext[1] = W_W'(u_frac) * W_W'(bW);
      wNext[2] = W_W'(aW)     * W_W'(v_frac);
      wNext[3] = W_W'(u_frac) * W_W'(v_frac);
    end
  end

  // Stage 1 register: weights, substituted pixels, sideband
  always_ff @(posedge clk) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1W     <= '0;
      s1Pix   <= '0;
      s1Sb    <= '0;
    end else if (adv) begin
      s1Valid <= in_valid;
      s1W     <= wNext;
      s1Pix   <= ePix;
      s1Sb    <= {in_sof, in_eol, in_sol};
    end
  end

  // Per-channel weight x pixel products
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      for (int unsigned c = 0; c < CH_NUM; c++) begin
        mNext[i][c] = M_W'(s1W[i]) * M_W'(s1Pix[i][c*CH_WIDTH +: CH_WIDTH]);
      end
    end
  end

  // Stage 2 register: products
  always_ff @(posedge clk) begin
    if (rst) begin
      s2Valid <= 1'b0;
      s2M     <= '0;
      s2Sb    <= '0;
    end else if (adv) begin
      s2Valid <= s1Valid;
      s2M     <= mNext;
      s2Sb    <= s1Sb;
    end
  end

  // Sum, round half-up, drop 2F fraction bits, clamp
  always_comb begin
    rNext = '0;
    sAcc  = '0;
    for (int unsigned c = 0; c < CH_NUM; c++) begin
      sAcc = HALF + S_W'(s2M[0][c]) + S_W'(s2M[1][c])
                  + S_W'(s2M[2][c]) + S_W'(s2M[3][c]);
      rNext[c*CH_WIDTH +: CH_WIDTH] = (sAcc >= SAT) ? {CH_WIDTH{1'b1}}
                                                    : sAcc[2*FRAC_WIDTH +: CH_WIDTH];
    end
  end

  // Stage 3 register: output pixel and sideband, held while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
      out_sol   <= 1'b0;
      out_eol   <= 1'b0;
      out_sof   <= 1'b0;
    end else if (adv) begin
      out_valid <= s2Valid;
      dout      <= rNext;
      out_sol   <= s2Sb[0];
      out_eol   <= s2Sb[1];
      out_sof   <= s2Sb[2];
    end
  end

  // Delivered-pixel counter, restarts at 1 on a start-of-frame beat
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_cnt <= '0;
    end else if (out_valid && out_ready) begin
      if (out_sof)
        pix_cnt <= 16'd1;
      else if (pix_cnt != 16'hFFFF)
        pix_cnt <= pix_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_scaler_interp_core.sv
// Testbench for scaler_interp_core: directed test-plan cases plus a
// randomized stream with backpressure against a behavioural model.
module tb_scaler_interp_core;

  localparam int CHN = 3;
  localparam int CHW = 8;
  localparam int FW  = 6;
  localparam int PW  = CHN * CHW;
  localparam int NB  = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          mode = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [PW-1:0] p00 = '0, p01 = '0, p10 = '0, p11 = '0;
  logic [FW-1:0] u_frac = '0, v_frac = '0;
  logic          x_edge = 1'b0, y_edge = 1'b0;
  logic          in_sol = 1'b0, in_eol = 1'b0, in_sof = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [PW-1:0] dout;
  logic          out_sol, out_eol, out_sof;
  logic [15:0]   pix_cnt;

  int passCnt  = 0;
  int totalCnt = 0;

  scaler_interp_core #(.CH_NUM(CHN), .CH_WIDTH(CHW), .FRAC_WIDTH(FW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .p00(p00), .p01(p01), .p10(p10), .p11(p11),
    .u_frac(u_frac), .v_frac(v_frac), .x_edge(x_edge), .y_edge(y_edge),
    .in_sol(in_sol), .in_eol(in_eol), .in_sof(in_sof),
    .out_valid(out_valid), .out_ready(out_ready), .dout(dout),
    .out_sol(out_sol), .out_eol(out_eol), .out_sof(out_sof), .pix_cnt(pix_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  // Reference: replicate edges, then weighted average of the four
  // neighbours in exact integer arithmetic with round-half-up.
  function automatic logic [PW-1:0] model(input bit nm, input logic [PW-1:0] a00,
      input logic [PW-1:0] a01, input logic [PW-1:0] a10, input logic [PW-1:0] a11,
      input int u, input int v, input bit xe, input bit ye);
    logic [PW-1:0] q[4];
    int px[4];
    int r, s, one, idx;
    logic [PW-1:0] res;
    one = 1 << FW;
    q[0] = a00; q[1] = a01; q[2] = a10; q[3] = a11;
    if (xe) begin q[1] = q[0]; q[3] = q[2]; end
    if (ye) begin q[2] = q[0]; q[3] = q[1]; end
    res = '0;
    for (int c = 0; c < CHN; c++) begin
      for (int k = 0; k < 4; k++) px[k] = int'(q[k][c*CHW +: CHW]);
      if (nm) begin
        idx = ((v >= one / 2) ? 2 : 0) + ((u >= one / 2) ? 1 : 0);
        r = px[idx];
      end else begin
        s = (one - u) * (one - v) * px[0] + u * (one - v) * px[1]
          + (one - u) * v * px[2] + u * v * px[3];
        r = (s + one * one / 2) / (one * one);
        if (r > (1 << CHW) - 1) r = (1 << CHW) - 1;
      end
      res[c*CHW +: CHW] = CHW'(r);
    end
    return res;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    totalCnt++;
    if (out_valid !== 1'b0 || dout !== '0 || pix_cnt !== 16'd0 ||
        {out_sol, out_eol, out_sof} !== 3'b000)
      $display("FAIL reset_state got v=%b d=%h cnt=%0d sb=%b exp v=0 d=0 cnt=0 sb=000",
               out_valid, dout, pix_cnt, {out_sol, out_eol, out_sof});
    else passCnt++;
    rst = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b exp 1", in_ready);
    else passCnt++;
  endtask

  // One isolated beat with out_ready high: checks value, latency, pulse width.
  task automatic run_directed(input string name, input bit nm,
      input logic [PW-1:0] a00, input logic [PW-1:0] a01,
      input logic [PW-1:0] a10, input logic [PW-1:0] a11,
      input int u, input int v, input bit xe, input bit ye, input logic [PW-1:0] expD);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    mode = nm; p00 = a00; p01 = a01; p10 = a10; p11 = a11;
    u_frac = FW'(u); v_frac = FW'(v); x_edge = xe; y_edge = ye;
    in_sol = 1'b1; in_eol = 1'b1; in_sof = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_sol = 1'b0; in_eol = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    totalCnt++;
    if (lat !== 3) $display("FAIL %s latency got %0d exp 3", name, lat);
    else passCnt++;
    totalCnt++;
    if (dout !== expD) $display("FAIL %s dout got %h exp %h", name, dout, expD);
    else passCnt++;
    totalCnt++;
    if ({out_sol, out_eol, out_sof} !== 3'b110)
      $display("FAIL %s sideband got %b exp 110", name, {out_sol, out_eol, out_sof});
    else passCnt++;
    @(negedge clk);
    totalCnt++;
    if (out_valid !== 1'b0) $display("FAIL %s pulse got out_valid %b exp 0", name, out_valid);
    else passCnt++;
  endtask

  task automatic test_passthrough();
    run_directed("passthru", 1'b0, 24'h563412, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF,
                 0, 0, 1'b0, 1'b0, 24'h563412);
  endtask

  task automatic test_bilinear();
    run_directed("bilin_u32", 1'b0, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF,
                 32, 17, 1'b0, 1'b0, 24'h808080);
    run_directed("bilin_u63", 1'b0, 24'h000000, 24'hFFFFFF, 24'h000000, 24'hFFFFFF,
                 63, 17, 1'b0, 1'b0, 24'hFBFBFB);
  endtask

  task automatic test_nearest();
    run_directed("near_31_32", 1'b1, 24'h0A0A0A, 24'h141414, 24'h1E1E1E, 24'h282828,
                 31, 32, 1'b0, 1'b0, 24'h1E1E1E);
    run_directed("near_32_31", 1'b1, 24'h0A0A0A, 24'h141414, 24'h1E1E1E, 24'h282828,
                 32, 31, 1'b0, 1'b0, 24'h141414);
    run_directed("near_32_32", 1'b1, 24'h0A0A0A, 24'h141414, 24'h1E1E1E, 24'h282828,
                 32, 32, 1'b0, 1'b0, 24'h282828);
  endtask

  task automatic test_edge();
    run_directed("edge_xy", 1'b0, 24'h000000, 24'h555555, 24'hAAAAAA, 24'hFFFFFF,
                 63, 63, 1'b1, 1'b1, 24'h000000);
    run_directed("edge_x", 1'b0, 24'h000000, 24'hFFFFFF, 24'h646464, 24'hC8C8C8,
                 0, 63, 1'b1, 1'b0, 24'h626262);
    run_directed("edge_y", 1'b0, 24'h102030, 24'h302010, 24'hFFFFFF, 24'hFFFFFF,
                 20, 63, 1'b0, 1'b1,
                 model(1'b0, 24'h102030, 24'h302010, 24'hFFFFFF, 24'hFFFFFF, 20, 63, 1'b0, 1'b1));
  endtask

  task automatic test_back_to_back_stream();
    logic [PW-1:0] bp[NB][4];
    int            bu[NB], bv[NB];
    bit            bm[NB], bxe[NB], bye[NB];
    bit [2:0]      bsb[NB];
    logic [PW-1:0] expQ[$];
    bit [2:0]      sbQ[$];
    logic [PW-1:0] heldD, expD;
    bit [2:0]      heldSb, expSb;
    bit            stalled;
    int            sent, got, expCnt, readyErr, stableErr, cntErr;
    for (int i = 0; i < NB; i++) begin
      for (int k = 0; k < 4; k++) bp[i][k] = PW'($urandom);
      bu[i]  = int'($urandom_range(0, 63));
      bv[i]  = int'($urandom_range(0, 63));
      bm[i]  = ($urandom_range(0, 3) == 0);
      bxe[i] = ($urandom_range(0, 3) == 0);
      bye[i] = ($urandom_range(0, 3) == 0);
      bsb[i] = {(i == 0 || i == 11) ? 1'b1 : 1'b0, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1))};
    end
    // start from a clean counter
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    sent = 0; got = 0; expCnt = 0; stalled = 1'b0;
    readyErr = 0; stableErr = 0; cntErr = 0;
    heldD = '0; heldSb = '0;
    for (int cyc = 0; cyc < 600 && got < NB; cyc++) begin
      @(negedge clk);
      if (stalled && (out_valid !== 1'b1 || dout !== heldD ||
                      {out_sof, out_eol, out_sol} !== heldSb)) begin
        if (stableErr < 3)
          $display("FAIL stall_hold got v=%b d=%h exp v=1 d=%h", out_valid, dout, heldD);
        stableErr++;
      end
      if (pix_cnt !== 16'(expCnt)) begin
        if (cntErr < 3) $display("FAIL pix_cnt got %0d exp %0d", pix_cnt, expCnt);
        cntErr++;
      end
      out_ready = ($urandom_range(0, 1) == 1);
      if (sent < NB) begin
        in_valid = ($urandom_range(0, 4) != 0);
        mode = bm[sent]; p00 = bp[sent][0]; p01 = bp[sent][1];
        p10 = bp[sent][2]; p11 = bp[sent][3];
        u_frac = FW'(bu[sent]); v_frac = FW'(bv[sent]);
        x_edge = bxe[sent]; y_edge = bye[sent];
        {in_sof, in_eol, in_sol} = bsb[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (in_ready !== !(out_valid && !out_ready)) begin
        if (readyErr < 3)
          $display("FAIL in_ready got %b exp %b", in_ready, !(out_valid && !out_ready));
        readyErr++;
      end
      if (out_valid && out_ready) begin
        totalCnt++;
        if (expQ.size() == 0) begin
          $display("FAIL stream_extra got d=%h exp no beat", dout);
        end else begin
          expD = expQ.pop_front();
          expSb = sbQ.pop_front();
          if (dout !== expD || {out_sof, out_eol, out_sol} !== expSb)
            $display("FAIL stream_beat%0d got d=%h sb=%b exp d=%h sb=%b", got, dout,
                     {out_sof, out_eol, out_sol}, expD, expSb);
          else passCnt++;
          expCnt = expSb[2] ? 1 : ((expCnt < 65535) ? expCnt + 1 : expCnt);
        end
        got++;
      end
      stalled = out_valid && !out_ready;
      heldD = dout;
      heldSb = {out_sof, out_eol, out_sol};
      if (in_valid && in_ready) begin
        expQ.push_back(model(bm[sent], bp[sent][0], bp[sent][1], bp[sent][2], bp[sent][3],
                             bu[sent], bv[sent], bxe[sent], bye[sent]));
        sbQ.push_back(bsb[sent]);
        sent++;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    totalCnt++;
    if (pix_cnt !== 16'(expCnt)) $display("FAIL pix_cnt_final got %0d exp %0d", pix_cnt, expCnt);
    else passCnt++;
    totalCnt++;
    if (got !== NB || expQ.size() !== 0)
      $display("FAIL stream_count got %0d left %0d exp %0d left 0", got, expQ.size(), NB);
    else passCnt++;
    totalCnt++;
    if (readyErr !== 0) $display("FAIL in_ready_rule got %0d errors exp 0", readyErr);
    else passCnt++;
    totalCnt++;
    if (stableErr !== 0) $display("FAIL stall_stable got %0d errors exp 0", stableErr);
    else passCnt++;
    totalCnt++;
    if (cntErr !== 0) $display("FAIL pix_cnt_track got %0d errors exp 0", cntErr);
    else passCnt++;
  endtask

  task automatic test_mid_reset();
    int stale;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mode = 1'b0; p00 = PW'($urandom); p01 = PW'($urandom);
      p10 = PW'($urandom); p11 = PW'($urandom);
      u_frac = FW'($urandom); v_frac = FW'($urandom);
      x_edge = 1'b0; y_edge = 1'b0; {in_sof, in_eol, in_sol} = 3'b111;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    totalCnt++;
    if (out_valid !== 1'b1) $display("FAIL midrst_inflight got out_valid %b exp 1", out_valid);
    else passCnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    totalCnt++;
    if (out_valid !== 1'b0 || pix_cnt !== 16'd0 || dout !== '0 ||
        {out_sol, out_eol, out_sof} !== 3'b000 || in_ready !== 1'b1)
      $display("FAIL midrst_state got v=%b cnt=%0d d=%h sb=%b rdy=%b exp v=0 cnt=0 d=0 sb=000 rdy=1",
               out_valid, pix_cnt, dout, {out_sol, out_eol, out_sof}, in_ready);
    else passCnt++;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    totalCnt++;
    if (stale !== 0) $display("FAIL midrst_stale got %0d beats exp 0", stale);
    else passCnt++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_bilinear();
    test_nearest();
    test_edge();
    test_back_to_back_stream();
    test_mid_reset();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
